// File: rtl/ram_view_pkg.sv
// ============================================================================
//  Module  : ram_view_pkg
//  Purpose : Shared definitions for the RAM viewer blocks: scan FSM state
//            encoding, default RAM geometry and the last-address constant.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_view_pkg;

  // Default geometry of the 32x4 switch-written RAM
  localparam int RV_ADDR_W = 5;
  localparam int RV_DATA_W = 4;

  // Highest address of the default-size RAM
  localparam logic [RV_ADDR_W-1:0] RV_LAST_ADDR = '1;

  // Scan sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_PACE    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pace_tick_gen.sv
// ============================================================================
//  Module  : pace_tick_gen
//  Purpose : Loadable down-counter producing a tick once PACE_CYCLES enabled
//            cycles have elapsed since the last load.
//  Ports   : i_clk   - clock
//            i_rst   - synchronous active-high reset (counter to 0)
//            i_load  - reload counter with PACE_CYCLES-1
//            i_en    - count enable; tick only asserts while enabled
//            o_tick  - high in the enabled cycle where the count is 0
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pace_tick_gen #(
  parameter int PACE_CYCLES = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tick
);

  localparam int                 c_cnt_w  = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(PACE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  // Counting N-1 down to 0 gives exactly N enabled cycles per interval
  assign o_tick = i_en && (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_reload;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_one;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_scan_reader.sv
// ============================================================================
//  Module  : ram_scan_reader
//  Purpose : Walks the RAM address space, one read per pace interval (or per
//            Step pulse), absorbs the registered read latency and presents
//            each {address, data} pair on a valid/ready output.
//  Ports   : i_clk, i_rst           - clock, synchronous active-high reset
//            i_start                - pulse: begin sweep at address 0
//            i_stop                 - level: abort sweep, return to idle
//            i_step                 - pulse: advance one address (step mode)
//            i_step_mode, i_loop    - sweep options, sampled at start
//            o_ram_addr, i_ram_data - RAM read port
//            o_out_addr, o_out_data - presented pair (registered)
//            o_out_valid, i_out_ready - output handshake
//            o_busy                 - high in every state except idle
//            o_done                 - pulse when a non-looping sweep ends
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_scan_reader
  import ram_view_pkg::*;
#(
  parameter int ADDR_W      = RV_ADDR_W,
  parameter int DATA_W      = RV_DATA_W,
  parameter int RD_LAT      = 1,
  parameter int PACE_CYCLES = 50_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_step,
  input  logic              i_step_mode,
  input  logic              i_loop,
  output logic [ADDR_W-1:0] o_ram_addr,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int                 c_lat_w     = $clog2(RD_LAT + 1);
  localparam logic [c_lat_w-1:0] c_lat_init  = c_lat_w'(RD_LAT);
  localparam logic [c_lat_w-1:0] c_lat_one   = c_lat_w'(1);
  localparam logic [ADDR_W-1:0]  c_last_addr = '1;
  localparam logic [ADDR_W-1:0]  c_addr_one  = ADDR_W'(1);

  state_t              r_state;
  state_t              w_next_state;

  logic [ADDR_W-1:0]   r_ram_addr;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_done;
  logic [c_lat_w-1:0]  r_lat_cnt;
  logic                r_step_mode;
  logic                r_loop;

  logic                w_latch_cfg;
  logic                w_lat_load;
  logic                w_lat_dec;
  logic                w_capture;
  logic                w_handshake;
  logic                w_addr_inc;
  logic                w_done_set;
  logic                w_pace_load;
  logic                w_pace_en;
  logic                w_pace_tick;

  assign o_ram_addr  = r_ram_addr;
  assign o_out_addr  = r_out_addr;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_done      = r_done;
  assign o_busy      = (r_state != ST_IDLE);

  // The pace counter only runs in paced mode; step mode ignores its tick
  assign w_pace_en = (r_state == ST_PACE) && !r_step_mode;

  pace_tick_gen #(
    .PACE_CYCLES (PACE_CYCLES)
  ) u_pace (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_pace_load),
    .i_en   (w_pace_en),
    .o_tick (w_pace_tick)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control strobes
  always_comb begin
    w_next_state = r_state;
    w_latch_cfg  = 1'b0;
    w_lat_load   = 1'b0;
    w_lat_dec    = 1'b0;
    w_capture    = 1'b0;
    w_handshake  = 1'b0;
    w_addr_inc   = 1'b0;
    w_done_set   = 1'b0;
    w_pace_load  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Stop dominates a simultaneous Start
        if (i_start && !i_stop) begin
          w_latch_cfg  = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        w_lat_load = 1'b1;
        if (i_stop) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (i_stop) begin
          w_next_state = ST_IDLE;
        end else if (r_lat_cnt <= c_lat_one) begin
          // Last latency cycle: RAM output now belongs to r_ram_addr
          w_capture    = 1'b1;
          w_next_state = ST_PRESENT;
        end else begin
          w_lat_dec = 1'b1;
        end
      end

      ST_PRESENT: begin
        // Stop is deferred until the pending word has been accepted
        if (i_out_ready) begin
          w_handshake = 1'b1;
          if ((r_ram_addr == c_last_addr) && !r_loop) begin
            w_done_set   = 1'b1;
            w_next_state = ST_IDLE;
          end else if (i_stop) begin
            w_next_state = ST_IDLE;
          end else begin
            w_addr_inc   = 1'b1;
            w_pace_load  = 1'b1;
            w_next_state = ST_PACE;
          end
        end
      end

      ST_PACE: begin
        if (i_stop) begin
          w_next_state = ST_IDLE;
        end else if (r_step_mode ? i_step : w_pace_tick) begin
          w_next_state = ST_ISSUE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Address, latency counter and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ram_addr  <= '0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_lat_cnt   <= '0;
      r_step_mode <= 1'b0;
      r_loop      <= 1'b0;
    end else begin
      r_done <= w_done_set;

      if (w_latch_cfg) begin
        r_step_mode <= i_step_mode;
        r_loop      <= i_loop;
        r_ram_addr  <= '0;
      end else if (w_addr_inc) begin
        // Natural wrap to 0 past the last address
        r_ram_addr <= r_ram_addr + c_addr_one;
      end

      if (w_lat_load) begin
        r_lat_cnt <= c_lat_init;
      end else if (w_lat_dec) begin
        r_lat_cnt <= r_lat_cnt - c_lat_one;
      end

      if (w_capture) begin
        r_out_data  <= i_ram_data;
        r_out_addr  <= r_ram_addr;
        r_out_valid <= 1'b1;
      end else if (w_handshake || (w_next_state == ST_IDLE)) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_scan_reader.sv
// ============================================================================
//  Module  : tb_ram_scan_reader
//  Purpose : Self-checking bench for ram_scan_reader. Two instances: a paced
//            reader (RD_LAT=1, PACE_CYCLES=4) and a fast reader (RD_LAT=2,
//            PACE_CYCLES=1), each fed by its own RAM model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_scan_reader;
  import ram_view_pkg::*;

  localparam int AW = 5;
  localparam int DW = 4;
  localparam int NW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } word_t;

  typedef struct {
    bit loop;
    int words;
    int exp_done;
    bit exp_busy;
  } run_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:NW-1];

  // ---------------- instance 1: RD_LAT=1, PACE_CYCLES=4 ----------------
  logic          rst = 1'b1, start = 1'b0, stop = 1'b0, step = 1'b0;
  logic          step_mode = 1'b0, loop_en = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] ram_addr, out_addr;
  logic [DW-1:0] ram_data, out_data;
  logic          out_valid, busy, done;

  ram_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .PACE_CYCLES(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_step(step),
    .i_step_mode(step_mode), .i_loop(loop_en), .o_ram_addr(ram_addr),
    .i_ram_data(ram_data), .o_out_addr(out_addr), .o_out_data(out_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_busy(busy), .o_done(done)
  );

  always_ff @(posedge clk) ram_data <= mem[ram_addr];

  // ---------------- instance 2: RD_LAT=2, PACE_CYCLES=1 ----------------
  logic          rst2 = 1'b1, start2 = 1'b0, stop2 = 1'b0, step2 = 1'b0;
  logic          sm2 = 1'b0, loop2 = 1'b0, ready2 = 1'b1;
  logic [AW-1:0] ram_addr2, out_addr2;
  logic [DW-1:0] ram_q1_2, ram_data2, out_data2;
  logic          out_valid2, busy2, done2;

  ram_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .PACE_CYCLES(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst2), .i_start(start2), .i_stop(stop2), .i_step(step2),
    .i_step_mode(sm2), .i_loop(loop2), .o_ram_addr(ram_addr2),
    .i_ram_data(ram_data2), .o_out_addr(out_addr2), .o_out_data(out_data2),
    .o_out_valid(out_valid2), .i_out_ready(ready2), .o_busy(busy2), .o_done(done2)
  );

  always_ff @(posedge clk) begin
    ram_q1_2  <= mem[ram_addr2];
    ram_data2 <= ram_q1_2;
  end

  // ---------------- scoreboards (sampled on the falling edge) ----------------
  word_t exp_q[$];
  word_t exp_q2[$];
  word_t w1, w2;
  int    hs_cnt = 0, done_cnt = 0;
  int    hs_cnt2 = 0, done_cnt2 = 0;
  int    last_hs2 = 0, gap2 = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      hs_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb1_extra: got addr=%0d data=%0h, required no output", out_addr, out_data);
      end else begin
        w1 = exp_q.pop_front();
        if ({out_addr, out_data} !== w1) begin
          errors++;
          $display("FAIL sb1_word: got addr=%0d data=%0h, required addr=%0d data=%0h",
                   out_addr, out_data, w1.a, w1.d);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done2) done_cnt2++;
    if (out_valid2 && ready2) begin
      hs_cnt2++;
      gap2     = cyc - last_hs2;
      last_hs2 = cyc;
      checks++;
      if (exp_q2.size() == 0) begin
        errors++;
        $display("FAIL sb2_extra: got addr=%0d data=%0h, required no output", out_addr2, out_data2);
      end else begin
        w2 = exp_q2.pop_front();
        if ({out_addr2, out_data2} !== w2) begin
          errors++;
          $display("FAIL sb2_word: got addr=%0d data=%0h, required addr=%0d data=%0h",
                   out_addr2, out_data2, w2.a, w2.d);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push_words(input int first, input int n, input bit to_second);
    word_t w;
    for (int k = first; k < first + n; k++) begin
      w.a = AW'(k % NW);
      w.d = DW'(k % NW);
      if (to_second) exp_q2.push_back(w);
      else           exp_q.push_back(w);
    end
  endtask

  task automatic wait_hs1(input int n, input int budget, input string name);
    int k = 0;
    while (hs_cnt < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (hs_cnt < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d handshakes, required %0d", name, hs_cnt, n);
    end
  endtask

  task automatic wait_hs2(input int n, input int budget, input string name);
    int k = 0;
    while (hs_cnt2 < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (hs_cnt2 < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d handshakes, required %0d", name, hs_cnt2, n);
    end
  endtask

  task automatic reset1();
    rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    hs_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(); step = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    run_vec_t vec[2];
    int       k;
    int       base;
    vec[0] = '{loop: 1'b0, words: 32, exp_done: 1, exp_busy: 1'b0};
    vec[1] = '{loop: 1'b1, words: 70, exp_done: 0, exp_busy: 1'b1};

    for (int i = 0; i < NW; i++) mem[i] = DW'(i);

    // Reset state
    tick();
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst  = 1'b0;
    rst2 = 1'b0;

    // Table-driven paced sweeps: one-shot and looping
    for (int v = 0; v < 2; v++) begin
      reset1();
      loop_en   = vec[v].loop;
      step_mode = 1'b0;
      out_ready = 1'b1;
      push_words(0, vec[v].words, 1'b0);
      pulse_start();
      wait_hs1(vec[v].words, vec[v].words * 12 + 50, "run_words");
      repeat (3) tick();
      chk("run_done_count", done_cnt, vec[v].exp_done);
      chk("run_busy", busy, vec[v].exp_busy);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("run_busy_after_stop", busy, 0);
      chk("run_queue_empty", exp_q.size(), 0);
    end

    // Consumer stall at address 7
    reset1();
    loop_en = 1'b0;
    push_words(0, NW, 1'b0);
    pulse_start();
    wait_hs1(7, 200, "pre_stall");
    out_ready = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin tick(); k++; end
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_addr", out_addr, 7);
      chk("stall_data", out_data, 7);
      chk("stall_ram_addr", ram_addr, 7);
      tick();
    end
    chk("stall_hs_count", hs_cnt, 7);
    out_ready = 1'b1;
    wait_hs1(NW, 400, "post_stall");
    repeat (3) tick();
    chk("stall_done_count", done_cnt, 1);
    chk("stall_busy", busy, 0);

    // Single-step mode with a dropped Step in WAIT
    reset1();
    step_mode = 1'b1;
    loop_en   = 1'b0;
    push_words(0, 4, 1'b0);
    pulse_start();
    wait_hs1(1, 50, "step_first");
    pulse_step();   // accepted in PACE
    tick();         // ISSUE
    pulse_step();   // lands in WAIT, must be dropped
    wait_hs1(2, 50, "step_second");
    repeat (20) tick();
    chk("step_dropped", hs_cnt, 2);
    chk("step_busy", busy, 1);
    pulse_step();
    wait_hs1(3, 50, "step_third");
    pulse_step();
    wait_hs1(4, 50, "step_fourth");
    pulse_start();  // ignored while busy
    repeat (20) tick();
    chk("step_total", hs_cnt, 4);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("step_stop_busy", busy, 0);
    chk("step_no_done", done_cnt, 0);

    // Stop in PACE after address 12, then restart
    reset1();
    step_mode = 1'b0;
    loop_en   = 1'b0;
    push_words(0, 13, 1'b0);
    pulse_start();
    wait_hs1(13, 300, "pre_stop");
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_valid", out_valid, 0);
    repeat (10) tick();
    chk("stop_no_done", done_cnt, 0);
    chk("stop_hs_count", hs_cnt, 13);
    chk("stop_queue_empty", exp_q.size(), 0);
    push_words(0, NW, 1'b0);
    pulse_start();
    chk("restart_addr", ram_addr, 0);
    chk("restart_busy", busy, 1);
    wait_hs1(13 + NW, 400, "restart");
    repeat (3) tick();
    chk("restart_done", done_cnt, 1);

    // Stop and Start in the same IDLE cycle
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    chk("stop_start_busy", busy, 0);
    repeat (5) tick();
    chk("stop_start_hs", hs_cnt, 13 + NW);

    // RD_LAT=2 instance: data alignment, word rate, reset in WAIT
    push_words(0, NW, 1'b1);
    start2 = 1'b1; tick(); start2 = 1'b0;
    wait_hs2(10, 100, "lat2_first");
    chk("lat2_word_gap", gap2, 5);
    k = 0;
    while (u_dut2.r_state != ST_WAIT && k < 20) begin tick(); k++; end
    rst2 = 1'b1; tick(); rst2 = 1'b0;
    chk("lat2_rst_ram_addr", ram_addr2, 0);
    chk("lat2_rst_out_addr", out_addr2, 0);
    chk("lat2_rst_out_data", out_data2, 0);
    chk("lat2_rst_valid", out_valid2, 0);
    chk("lat2_rst_busy", busy2, 0);
    chk("lat2_rst_done", done2, 0);
    repeat (10) tick();
    chk("lat2_idle_busy", busy2, 0);
    chk("lat2_no_done", done_cnt2, 0);
    exp_q2.delete();
    base = hs_cnt2;
    push_words(0, NW, 1'b1);
    start2 = 1'b1; tick(); start2 = 1'b0;
    wait_hs2(base + NW, 400, "lat2_sweep");
    repeat (3) tick();
    chk("lat2_done", done_cnt2, 1);
    chk("lat2_busy", busy2, 0);
    chk("lat2_queue_empty", exp_q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
